// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: per-key FSM states and the
// elaboration-time helpers that size the tick prescaler and key counters.
package key_conditioner_pkg;

  // Per-key debounce / auto-repeat states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // released and stable
    ST_DBP  = 3'd1,  // press seen, waiting for it to stay stable
    ST_HELD = 3'd2,  // press accepted, waiting for the first repeat
    ST_RPT  = 3'd3,  // auto-repeating at the repeat rate
    ST_DBR  = 3'd4   // release seen while held, waiting for it to stay stable
  } key_state_e;

  localparam int unsigned MS_PER_S = 1000;

  // Number of bits needed to hold every value in 0..max_val (never less than 1).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Clock cycles per 1 ms tick.
  function automatic int unsigned tick_div(input int unsigned clk_freq);
    return clk_freq / MS_PER_S;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the board inputs and the clock logic: raw keys in,
// conditioned level and pulse outputs back.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4
);

  logic [N_KEYS-1:0] KeyIn;       // raw asynchronous key inputs
  logic [N_KEYS-1:0] KeyLevel;    // debounced level, 1 = pressed
  logic [N_KEYS-1:0] KeyPress;    // 1-cycle pulse on accepted press
  logic [N_KEYS-1:0] KeyRelease;  // 1-cycle pulse on accepted release
  logic [N_KEYS-1:0] KeyRepeat;   // press pulse plus auto-repeat pulses

  // Key source side (board / bench).
  modport master (
    output KeyIn,
    input  KeyLevel, KeyPress, KeyRelease, KeyRepeat
  );

  // Conditioner side.
  modport slave (
    input  KeyIn,
    output KeyLevel, KeyPress, KeyRelease, KeyRepeat
  );

endinterface

// File: rtl/key_conditioner_key_fsm.sv
// One key channel: 2-flop synchroniser, polarity normalisation, debounce /
// auto-repeat FSM with its tick counter, and registered level/pulse outputs.
module key_conditioner_key_fsm
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 200,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CNT_W =
    width_for(max3(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS));
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY_MS);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE_MS);
  // Raw level of a released key; the synchroniser resets to it so no
  // phantom press is seen when reset lifts.
  localparam logic RAW_IDLE = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             k;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hit_deb, hit_delay, hit_rate;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  // Two-stage synchroniser for the asynchronous raw key.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // k = 1 means pressed, whatever the board polarity.
  assign k = sync2_q ^ ACTIVE_LOW;

  // Counter value this tick would produce, and which limit it reaches.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign hit_deb   = (cnt_inc == DEB_C);
  assign hit_delay = (cnt_inc == DELAY_C);
  assign hit_rate  = (cnt_inc == RATE_C);

  // State register, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Next state and counter; a k transition always beats a same-cycle tick.
  // NOTE: every variable gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (k) begin
          state_d = ST_DBP;
          cnt_d   = '0;
        end
      end
      ST_DBP: begin
        if (!k) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (hit_deb) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_HELD: begin
        if (!k) begin
          state_d = ST_DBR;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (hit_delay) begin
            state_d = ST_RPT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_RPT: begin
        if (!k) begin
          state_d = ST_DBR;
          cnt_d   = '0;
        end else if (tick_i) begin
          cnt_d = hit_rate ? '0 : cnt_inc;
        end
      end
      ST_DBR: begin
        // A key that comes back during release debounce restarts the
        // repeat delay rather than resuming the old repeat train.
        if (k) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (hit_deb) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: pulses fire on the accepting tick, level follows the next state.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    level_d   = (state_d == ST_HELD) || (state_d == ST_RPT) || (state_d == ST_DBR);
    case (state_q)
      ST_DBP: begin
        if (k && tick_i && hit_deb) begin
          press_d  = 1'b1;
          repeat_d = 1'b1;
        end
      end
      ST_HELD: repeat_d  = k && tick_i && hit_delay;
      ST_RPT:  repeat_d  = k && tick_i && hit_rate;
      ST_DBR:  release_d = !k && tick_i && hit_deb;
      default: ;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: shared 1 ms tick prescaler feeding N_KEYS independent
// key channels.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned CLK_FREQ        = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 200,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic               CP50,
  input logic               nCR,
  key_conditioner_if.slave  kif
);

  localparam int unsigned      TICK_DIV = tick_div(CLK_FREQ);
  localparam int unsigned      PRE_W    = width_for(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] TICK_TC  = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              tick;
  logic [N_KEYS-1:0] level_w, press_w, release_w, repeat_w;

  // Free-running prescaler; tick is high for the one cycle at terminal count.
  assign tick = (presc_q == TICK_TC);

  // Prescaler next value: wrap at terminal count.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge CP50 or negedge nCR) begin
    if (!nCR) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_conditioner_key_fsm #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_key (
      .clk       (CP50),
      .rst_n     (nCR),
      .tick_i    (tick),
      .key_raw_i (kif.KeyIn[i]),
      .level_o   (level_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .repeat_o  (repeat_w[i])
    );
  end

  assign kif.KeyLevel   = level_w;
  assign kif.KeyPress   = press_w;
  assign kif.KeyRelease = release_w;
  assign kif.KeyRepeat  = repeat_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed key scenarios, an event-level model of
// the debounce/repeat rules checked on every cycle, and literal timing checks.
module tb_key_conditioner;

  localparam int N     = 4;
  localparam int TDIV  = 10;  // 10 kHz clock -> tick every 10 cycles
  localparam int DEB   = 3;
  localparam int DELAY = 5;
  localparam int RATE  = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  key_conditioner_if #(.N_KEYS(N)) kif ();

  key_conditioner #(
    .N_KEYS          (N),
    .CLK_FREQ        (10000),
    .DEBOUNCE_MS     (DEB),
    .REPEAT_DELAY_MS (DELAY),
    .REPEAT_RATE_MS  (RATE),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .CP50 (clk),
    .nCR  (rst_n),
    .kif  (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on key edges and elapsed ticks: a level change is accepted after DEB
  // ticks with no edge; while accepted-held, repeats fire DELAY ticks after
  // the anchor (acceptance or re-press) and then every RATE ticks.
  logic [N-1:0] exp_level   = '0;
  logic [N-1:0] exp_press   = '0;
  logic [N-1:0] exp_release = '0;
  logic [N-1:0] exp_repeat  = '0;
  logic [N-1:0] m_s1 = '1, m_s2 = '1, m_kprev = '0, m_lvl = '0;
  int m_run [N];
  int m_rep [N];
  int m_target [N];
  int m_cycles = 0;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_kprev = '0; m_lvl = '0; m_cycles = 0;
    exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_rep[i] = 0; m_target[i] = DELAY;
    end
  endtask

  task automatic model_step();
    bit           tick, edge_seen;
    logic [N-1:0] k;
    tick = ((m_cycles % TDIV) == TDIV - 1);
    m_cycles++;
    k    = ~m_s2;
    m_s2 = m_s1;
    m_s1 = kif.KeyIn;
    exp_press = '0; exp_release = '0; exp_repeat = '0;
    for (int i = 0; i < N; i++) begin
      edge_seen = (k[i] != m_kprev[i]);
      if (edge_seen) m_run[i] = 0;
      else if (tick) m_run[i]++;
      if (k[i] != m_lvl[i]) begin
        if (!edge_seen && tick && m_run[i] == DEB) begin
          m_lvl[i] = k[i];
          if (k[i]) begin
            exp_press[i]  = 1'b1;
            exp_repeat[i] = 1'b1;
            m_rep[i]      = 0;
            m_target[i]   = DELAY;
          end else begin
            exp_release[i] = 1'b1;
          end
        end
      end else if (m_lvl[i]) begin
        if (edge_seen) begin
          m_rep[i]    = 0;
          m_target[i] = DELAY;
        end else if (tick) begin
          m_rep[i]++;
          if (m_rep[i] == m_target[i]) begin
            exp_repeat[i] = 1'b1;
            m_rep[i]      = 0;
            m_target[i]   = RATE;
          end
        end
      end
      m_kprev[i] = k[i];
    end
    exp_level = m_lvl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int           press_cnt [N];
  int           release_cnt [N];
  int           fall_cnt [N];
  int           press_t [N];
  int           release_t [N];
  int           rep_n [N];
  int           rep_t [N][16];
  logic [N-1:0] press_rep = '0;
  logic [N-1:0] last_press_vec = '0;
  logic [N-1:0] prev_level = '0;

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; fall_cnt[i] = 0;
      press_t[i] = 0; release_t[i] = 0; rep_n[i] = 0;
    end
    press_rep = '0;
    last_press_vec = '0;
  endtask

  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      check($sformatf("KeyLevel cyc %0d", cyc),   kif.KeyLevel,   exp_level);
      check($sformatf("KeyPress cyc %0d", cyc),   kif.KeyPress,   exp_press);
      check($sformatf("KeyRelease cyc %0d", cyc), kif.KeyRelease, exp_release);
      check($sformatf("KeyRepeat cyc %0d", cyc),  kif.KeyRepeat,  exp_repeat);
      if (kif.KeyPress != '0) last_press_vec = kif.KeyPress;
      for (int i = 0; i < N; i++) begin
        if (kif.KeyPress[i] === 1'b1) begin
          press_cnt[i]++;
          press_t[i]   = cyc;
          press_rep[i] = kif.KeyRepeat[i];
        end
        if (kif.KeyRelease[i] === 1'b1) begin
          release_cnt[i]++;
          release_t[i] = cyc;
        end
        if (kif.KeyRepeat[i] === 1'b1) begin
          if (rep_n[i] < 16) rep_t[i][rep_n[i]] = cyc;
          rep_n[i]++;
        end
        if (prev_level[i] === 1'b1 && kif.KeyLevel[i] === 1'b0) fall_cnt[i]++;
      end
      prev_level = kif.KeyLevel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_press(input int key, input int budget, input string name);
    for (int i = 0; i < budget && press_cnt[key] == 0; i++) wait_cycles(1);
    check(name, press_cnt[key], 1);
  endtask

  int t0;

  initial begin
    rst_n     = 1'b0;
    kif.KeyIn = '1;
    wait_cycles(3);
    check("reset outputs", {kif.KeyLevel, kif.KeyPress, kif.KeyRelease, kif.KeyRepeat}, 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // 1: clean press on key 0. Sync (2) + IDLE step (1) + 3 ticks of free
    // phase puts the press 24..33 cycles after the raw edge.
    clear_stats();
    t0 = cyc;
    kif.KeyIn[0] = 1'b0;
    wait_cycles(200);
    check("t1 press count", press_cnt[0], 1);
    check_range("t1 press latency", press_t[0] - t0, 24, 33);
    check("t1 repeat with press", press_rep[0], 1);
    check("t1 level held", kif.KeyLevel[0], 1);
    t0 = cyc;
    kif.KeyIn[0] = 1'b1;
    wait_cycles(40);
    check("t1 release count", release_cnt[0], 1);
    check_range("t1 release latency", release_t[0] - t0, 24, 33);
    check("t1 level released", kif.KeyLevel[0], 0);

    // 2: key 1 bounces every 4 cycles, then settles pressed.
    clear_stats();
    for (int i = 0; i < 11; i++) begin
      kif.KeyIn[1] = ~kif.KeyIn[1];
      if (i < 10) wait_cycles(4);
    end
    t0 = cyc;
    wait_cycles(60);
    check("t2 press count", press_cnt[1], 1);
    check("t2 release count", release_cnt[1], 0);
    check_range("t2 press latency", press_t[1] - t0, 24, 33);
    kif.KeyIn[1] = 1'b1;
    wait_cycles(40);

    // 3: long hold on key 2: repeats at press, +50, then every 20.
    clear_stats();
    kif.KeyIn[2] = 1'b0;
    wait_press(2, 60, "t3 press seen");
    wait_cycles(155);
    check("t3 repeat count", rep_n[2], 7);
    check("t3 first repeat at press", rep_t[2][0], press_t[2]);
    check("t3 repeat delay", rep_t[2][1] - rep_t[2][0], 50);
    for (int j = 2; j < 7; j++)
      check($sformatf("t3 repeat gap %0d", j), rep_t[2][j] - rep_t[2][j-1], 20);

    // 4: 15-cycle release glitch on held key 2 restarts the repeat delay.
    clear_stats();
    kif.KeyIn[2] = 1'b1;
    wait_cycles(15);
    kif.KeyIn[2] = 1'b0;
    t0 = cyc;
    wait_cycles(70);
    check("t4 no release", release_cnt[2], 0);
    check("t4 level never dropped", fall_cnt[2], 0);
    check("t4 no new press", press_cnt[2], 0);
    check_range("t4 repeat after glitch", rep_t[2][0] - t0, 44, 53);
    kif.KeyIn[2] = 1'b1;
    wait_cycles(40);

    // 5: reset while key 3 is auto-repeating; fresh press after reset.
    clear_stats();
    kif.KeyIn[3] = 1'b0;
    wait_press(3, 60, "t5 press seen");
    wait_cycles(60);
    check("t5 level before reset", kif.KeyLevel[3], 1);
    rst_n = 1'b0;
    #1;
    check("t5 outputs in reset", {kif.KeyLevel, kif.KeyPress, kif.KeyRelease, kif.KeyRepeat}, 0);
    wait_cycles(3);
    clear_stats();
    rst_n = 1'b1;
    t0 = cyc;
    wait_press(3, 60, "t5 press after reset");
    // Prescaler restarts at 0: ticks on edges 10, 20, 30 after release.
    check("t5 press latency after reset", press_t[3] - t0, 30);
    kif.KeyIn[3] = 1'b1;
    wait_cycles(40);

    // 6: keys 0 and 1 together; releasing 0 leaves 1 repeating.
    clear_stats();
    kif.KeyIn[1:0] = 2'b00;
    wait_press(0, 60, "t6 press seen");
    check("t6 simultaneous press", last_press_vec, 4'b0011);
    check("t6 key1 press count", press_cnt[1], 1);
    wait_cycles(60);
    clear_stats();
    kif.KeyIn[0] = 1'b1;
    wait_cycles(60);
    check("t6 key0 release", release_cnt[0], 1);
    check("t6 key1 no release", release_cnt[1], 0);
    check("t6 key1 level held", kif.KeyLevel[1], 1);
    check("t6 key1 repeat count", rep_n[1], 3);
    check("t6 key1 gap 1", rep_t[1][1] - rep_t[1][0], 20);
    check("t6 key1 gap 2", rep_t[1][2] - rep_t[1][1], 20);

    kif.KeyIn = '1;
    wait_cycles(40);
    check("final levels", kif.KeyLevel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
